board_state: RTL and testbench

- Game-state stage for the 8x8 minesweeper board; sits directly upstream of the tile renderer.
- Owns the mine, flag and step maps and the cursor position, and decodes one-cycle move, flag and step command pulses.
- Counts mines adjacent to each newly stepped tile.
- Requests a board redraw from the renderer by a level/done handshake.

---
 rtl/minesweeper_pkg.sv | 40 ++++
 rtl/adj_mine_counter.sv | 70 +++++++
 rtl/board_state.sv | 211 +++++++++++++++++++++
 tb/tb_board_state.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared constants and helpers for the 8x8 minesweeper game-state slice:
// board geometry, state encoding, neighbour offsets and tile indexing.
package minesweeper_pkg;

  localparam int BOARD_W = 8;
  localparam int BOARD_H = 8;
  localparam int MAP_W   = BOARD_W * BOARD_H;
  localparam int X_W     = 3;
  localparam int Y_W     = 3;
  localparam int IDX_W   = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_REDRAW = 3'd2;
  localparam logic [2:0] ST_LOST   = 3'd3;
  localparam logic [2:0] ST_WON    = 3'd4;

  // Neighbour order: NW, N, NE, W, E, SW, S, SE
  function automatic logic signed [4:0] nb_dx(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd5: nb_dx = -5'sd1;
      3'd2, 3'd4, 3'd7: nb_dx = 5'sd1;
      default:          nb_dx = 5'sd0;
    endcase
  endfunction

  function automatic logic signed [4:0] nb_dy(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: nb_dy = -5'sd1;
      3'd5, 3'd6, 3'd7: nb_dy = 5'sd1;
      default:          nb_dy = 5'sd0;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] tile_idx(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    tile_idx = IDX_W'(y) * IDX_W'(BOARD_W) + IDX_W'(x);
  endfunction

endpackage

// File: rtl/adj_mine_counter.sv
// Walks the eight neighbours of a centre tile, one per cycle, and
// accumulates how many in-bounds neighbours hold a mine.
module adj_mine_counter
  import minesweeper_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [MAP_W-1:0] mine_map_i,
  input  logic [X_W-1:0]   cx_i,
  input  logic [Y_W-1:0]   cy_i,
  output logic [3:0]       count_o,
  output logic             done_o
);

  localparam logic signed [4:0] W_S = $signed(5'(BOARD_W));
  localparam logic signed [4:0] H_S = $signed(5'(BOARD_H));

  logic [2:0]        idx_q, idx_d;
  logic [3:0]        acc_q, acc_d;
  logic              run_q, run_d;
  logic signed [4:0] nx_s, ny_s;
  logic              inb_s, hit_s;

  // Neighbour coordinate, bounds check and mine lookup for the current index
  always_comb begin
    nx_s  = $signed({2'b00, cx_i}) + nb_dx(idx_q);
    ny_s  = $signed({2'b00, cy_i}) + nb_dy(idx_q);
    inb_s = (nx_s >= 5'sd0) && (nx_s < W_S) && (ny_s >= 5'sd0) && (ny_s < H_S);
    if (inb_s) begin
      hit_s = mine_map_i[tile_idx(nx_s[X_W-1:0], ny_s[Y_W-1:0])];
    end else begin
      hit_s = 1'b0;
    end
  end

  // Index/accumulator sequencing; the final sum includes the last neighbour
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    run_d = run_q;
    if (start_i) begin
      idx_d = 3'd0;
      acc_d = 4'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = acc_q + {3'b000, hit_s};
      idx_d = idx_q + 3'd1;
      run_d = (idx_q != 3'd7);
    end else begin
      run_d = 1'b0;
    end
    count_o = acc_q + {3'b000, hit_s};
    done_o  = run_q && (idx_q == 3'd7);
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q <= 3'd0;
      acc_q <= 4'd0;
      run_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/board_state.sv
// Minesweeper game-state stage: owns mine/flag/step maps and the cursor,
// decodes command pulses, counts adjacent mines and hands off redraws.
module board_state
  import minesweeper_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             mine_load,
  input  logic [MAP_W-1:0] mine_in,
  input  logic             mv_up,
  input  logic             mv_down,
  input  logic             mv_left,
  input  logic             mv_right,
  input  logic             flag_req,
  input  logic             step_req,
  input  logic             draw_done,
  output logic [MAP_W-1:0] mineMap,
  output logic [MAP_W-1:0] flagMap,
  output logic [MAP_W-1:0] stepMap,
  output logic [X_W-1:0]   cursor_x,
  output logic [Y_W-1:0]   cursor_y,
  output logic [3:0]       adj_count,
  output logic             adj_valid,
  output logic             redraw,
  output logic             busy,
  output logic             lost,
  output logic             won
);

  localparam logic [X_W-1:0] MAX_X = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] MAX_Y = Y_W'(BOARD_H - 1);

  logic [2:0]       state_q, state_d;
  logic [MAP_W-1:0] mine_q, mine_d, flag_q, flag_d, step_q, step_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic [3:0]       adj_count_q, adj_count_d;
  logic             adj_valid_q, adj_valid_d;
  logic             redraw_q, redraw_d, busy_q, busy_d;
  logic             lost_q, lost_d, won_q, won_d;
  logic             load_s, cnt_start_s, cnt_done_s;
  logic [3:0]       cnt_count_s;
  logic [IDX_W-1:0] cur_s;

  adj_mine_counter u_counter (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (cnt_start_s),
    .mine_map_i (mine_q),
    .cx_i       (cx_q),
    .cy_i       (cy_q),
    .count_o    (cnt_count_s),
    .done_o     (cnt_done_s)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    mine_d      = mine_q;
    flag_d      = flag_q;
    step_d      = step_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    adj_count_d = adj_count_q;
    adj_valid_d = 1'b0;
    lost_d      = lost_q;
    won_d       = won_q;
    cnt_start_s = 1'b0;
    cur_s       = tile_idx(cx_q, cy_q);
    load_s      = mine_load && ((state_q == ST_IDLE) || (state_q == ST_LOST) ||
                                (state_q == ST_WON));
    if (load_s) begin
      mine_d  = mine_in;
      flag_d  = '0;
      step_d  = '0;
      cx_d    = '0;
      cy_d    = '0;
      lost_d  = 1'b0;
      won_d   = 1'b0;
      state_d = ST_REDRAW;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Only the highest-priority pulse is considered, even if it is refused
          if (step_req) begin
            if (!flag_q[cur_s] && !step_q[cur_s]) begin
              step_d[cur_s] = 1'b1;
              if (mine_q[cur_s]) begin
                lost_d  = 1'b1;
                state_d = ST_REDRAW;
              end else begin
                cnt_start_s = 1'b1;
                state_d     = ST_COUNT;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end else if (flag_req) begin
            if (!step_q[cur_s]) begin
              flag_d[cur_s] = ~flag_q[cur_s];
              state_d       = ST_REDRAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (mv_up) begin
            if (cy_q != 3'd0) begin
              cy_d = cy_q - 3'd1; state_d = ST_REDRAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (mv_down) begin
            if (cy_q != MAX_Y) begin
              cy_d = cy_q + 3'd1; state_d = ST_REDRAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (mv_left) begin
            if (cx_q != 3'd0) begin
              cx_d = cx_q - 3'd1; state_d = ST_REDRAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (mv_right) begin
            if (cx_q != MAX_X) begin
              cx_d = cx_q + 3'd1; state_d = ST_REDRAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (cnt_done_s) begin
            adj_count_d = cnt_count_s;
            adj_valid_d = 1'b1;
            won_d       = &(step_q | mine_q);
            state_d     = ST_REDRAW;
          end else begin
            state_d = ST_COUNT;
          end
        end
        ST_REDRAW: begin
          if (draw_done) begin
            if (lost_q) begin
              state_d = ST_LOST;
            end else if (won_q) begin
              state_d = ST_WON;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_REDRAW;
          end
        end
        ST_LOST: state_d = ST_LOST;
        ST_WON:  state_d = ST_WON;
        default: state_d = ST_IDLE;
      endcase
    end
    redraw_d = (state_d == ST_REDRAW);
    busy_d   = (state_d == ST_COUNT) || (state_d == ST_REDRAW);
  end

  // State and board registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mine_q      <= '0;
      flag_q      <= '0;
      step_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      adj_count_q <= 4'd0;
      adj_valid_q <= 1'b0;
      redraw_q    <= 1'b0;
      busy_q      <= 1'b0;
      lost_q      <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mine_q      <= mine_d;
      flag_q      <= flag_d;
      step_q      <= step_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      adj_count_q <= adj_count_d;
      adj_valid_q <= adj_valid_d;
      redraw_q    <= redraw_d;
      busy_q      <= busy_d;
      lost_q      <= lost_d;
      won_q       <= won_d;
    end
  end

  // Output drive from registered state
  always_comb begin
    mineMap   = mine_q;
    flagMap   = flag_q;
    stepMap   = step_q;
    cursor_x  = cx_q;
    cursor_y  = cy_q;
    adj_count = adj_count_q;
    adj_valid = adj_valid_q;
    redraw    = redraw_q;
    busy      = busy_q;
    lost      = lost_q;
    won       = won_q;
  end

endmodule

// File: tb/tb_board_state.sv
// Directed, table-driven bench for board_state with hand-computed expectations.
module tb_board_state;

  localparam int C_NONE = 0, C_UP = 1, C_DOWN = 2, C_LEFT = 3, C_RIGHT = 4;
  localparam int C_FLAG = 5, C_STEP = 6, C_FLAG_RIGHT = 7, C_LOAD = 8;

  typedef struct {
    int          cmd;
    logic [2:0]  ex;
    logic [2:0]  ey;
    logic        erd;
    logic [63:0] eflag;
    logic [63:0] estep;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mine_load = 1'b0;
  logic [63:0] mine_in = 64'h0;
  logic        mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
  logic        flag_req = 1'b0, step_req = 1'b0, draw_done = 1'b0;
  logic [63:0] mineMap, flagMap, stepMap;
  logic [2:0]  cursor_x, cursor_y;
  logic [3:0]  adj_count;
  logic        adj_valid, redraw, busy, lost, won;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  board_state dut (
    .clk(clk), .resetn(resetn), .mine_load(mine_load), .mine_in(mine_in),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .flag_req(flag_req), .step_req(step_req), .draw_done(draw_done),
    .mineMap(mineMap), .flagMap(flagMap), .stepMap(stepMap),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .adj_count(adj_count),
    .adj_valid(adj_valid), .redraw(redraw), .busy(busy), .lost(lost), .won(won)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int cmd);
    mv_up     = (cmd == C_UP);
    mv_down   = (cmd == C_DOWN);
    mv_left   = (cmd == C_LEFT);
    mv_right  = (cmd == C_RIGHT) || (cmd == C_FLAG_RIGHT);
    flag_req  = (cmd == C_FLAG) || (cmd == C_FLAG_RIGHT);
    step_req  = (cmd == C_STEP);
    mine_load = (cmd == C_LOAD);
    tick();
    {mv_up, mv_down, mv_left, mv_right, flag_req, step_req, mine_load} = 7'b0;
  endtask

  // Wait (bounded) for a redraw request, then complete it with draw_done.
  task automatic finish_redraw(input string name);
    int n = 0;
    while (!redraw && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_redraw_seen"}, redraw, 1'b1);
    if (redraw) begin
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      chk({name, "_redraw_drop"}, redraw, 1'b0);
      chk({name, "_busy_idle"}, busy, 1'b0);
    end
  endtask

  task automatic move(input int cmd);
    pulse(cmd);
    if (redraw) finish_redraw("move");
  endtask

  function automatic vec_t mk(input int cmd, input logic [2:0] ex, input logic [2:0] ey,
                              input logic erd, input logic [63:0] ef, input logic [63:0] es);
    vec_t v;
    v.cmd = cmd; v.ex = ex; v.ey = ey; v.erd = erd; v.eflag = ef; v.estep = es;
    return v;
  endfunction

  initial begin
    // Cursor/flag command table, starting at (0,0) with a mine at bit 1
    vq.push_back(mk(C_LEFT,  3'd0, 3'd0, 1'b0, 64'h0, 64'h0));
    vq.push_back(mk(C_UP,    3'd0, 3'd0, 1'b0, 64'h0, 64'h0));
    for (int k = 1; k <= 7; k++) vq.push_back(mk(C_RIGHT, 3'(k), 3'd0, 1'b1, 64'h0, 64'h0));
    vq.push_back(mk(C_RIGHT, 3'd7, 3'd0, 1'b0, 64'h0, 64'h0));
    vq.push_back(mk(C_DOWN,  3'd7, 3'd1, 1'b1, 64'h0, 64'h0));
    vq.push_back(mk(C_LEFT,  3'd6, 3'd1, 1'b1, 64'h0, 64'h0));
    vq.push_back(mk(C_UP,    3'd6, 3'd0, 1'b1, 64'h0, 64'h0));
    for (int k = 5; k >= 1; k--) vq.push_back(mk(C_LEFT, 3'(k), 3'd0, 1'b1, 64'h0, 64'h0));
    vq.push_back(mk(C_FLAG,       3'd1, 3'd0, 1'b1, 64'h2, 64'h0));
    vq.push_back(mk(C_STEP,       3'd1, 3'd0, 1'b0, 64'h2, 64'h0));
    vq.push_back(mk(C_FLAG,       3'd1, 3'd0, 1'b1, 64'h0, 64'h0));
    vq.push_back(mk(C_FLAG_RIGHT, 3'd1, 3'd0, 1'b1, 64'h2, 64'h0));
    vq.push_back(mk(C_FLAG,       3'd1, 3'd0, 1'b1, 64'h0, 64'h0));

    // Reset state
    tick(); tick();
    chk("rst_mine", mineMap, 64'h0);
    chk("rst_flag", flagMap, 64'h0);
    chk("rst_step", stepMap, 64'h0);
    chk("rst_cursor", {cursor_y, cursor_x}, 6'h0);
    chk("rst_flags", {adj_count, adj_valid, redraw, busy, lost, won}, 9'h0);
    resetn = 1'b1;
    tick();

    // New game with a mine at bit 1; redraw holds until draw_done
    mine_in = 64'h0000_0000_0000_0002;
    pulse(C_LOAD);
    chk("load_mine", mineMap, 64'h2);
    chk("load_cursor", {cursor_y, cursor_x}, 6'h0);
    chk("load_redraw", redraw, 1'b1);
    chk("load_busy", busy, 1'b1);
    tick(); tick();
    chk("load_redraw_hold", redraw, 1'b1);
    finish_redraw("load");

    for (int i = 0; i < vq.size(); i++) begin
      pulse(vq[i].cmd);
      chk($sformatf("v%0d_cx", i), cursor_x, vq[i].ex);
      chk($sformatf("v%0d_cy", i), cursor_y, vq[i].ey);
      chk($sformatf("v%0d_redraw", i), redraw, vq[i].erd);
      chk($sformatf("v%0d_flag", i), flagMap, vq[i].eflag);
      chk($sformatf("v%0d_step", i), stepMap, vq[i].estep);
      if (vq[i].erd) finish_redraw($sformatf("v%0d", i));
    end

    // Adjacent count at the corner: mines at 1, 8, 9
    mine_in = 64'h0000_0000_0000_0302;
    pulse(C_LOAD);
    finish_redraw("load2");
    pulse(C_STEP);
    chk("step00_map", stepMap, 64'h1);
    chk("step00_busy", busy, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) mv_right = 1'b1;
      tick();
      mv_right = 1'b0;
      chk($sformatf("count_c%0d_valid", c), adj_valid, 1'b0);
    end
    chk("count_move_dropped", cursor_x, 3'd0);
    tick();
    chk("step00_valid", adj_valid, 1'b1);
    chk("step00_count", adj_count, 4'd3);
    chk("step00_redraw", redraw, 1'b1);
    chk("step00_lost", lost, 1'b0);
    tick();
    chk("step00_valid_pulse", adj_valid, 1'b0);
    finish_redraw("step00");

    // Interior tile (2,1): neighbours at bits 1 and 9 are mines
    move(C_RIGHT); move(C_RIGHT); move(C_DOWN);
    pulse(C_STEP);
    for (int c = 0; c < 8; c++) tick();
    chk("step21_valid", adj_valid, 1'b1);
    chk("step21_count", adj_count, 4'd2);
    chk("step21_map", stepMap, 64'h401);
    finish_redraw("step21");

    // Step on the mine at (1,0)
    move(C_UP); move(C_LEFT);
    pulse(C_STEP);
    chk("mine_lost", lost, 1'b1);
    chk("mine_redraw", redraw, 1'b1);
    chk("mine_map", stepMap, 64'h403);
    finish_redraw("mine");
    chk("lost_sticky", lost, 1'b1);
    pulse(C_RIGHT);
    chk("lost_move_dropped", cursor_x, 3'd1);
    chk("lost_no_redraw", redraw, 1'b0);
    pulse(C_STEP);
    chk("lost_step_dropped", stepMap, 64'h403);

    // Win run: single mine at bit 63, step every other tile (snake order)
    mine_in = 64'h8000_0000_0000_0000;
    pulse(C_LOAD);
    chk("load3_lost_clr", lost, 1'b0);
    chk("load3_step_clr", stepMap, 64'h0);
    finish_redraw("load3");
    for (int y = 0; y < 8; y++) begin
      for (int k = 0; k < 8; k++) begin
        int x;
        x = (y % 2 == 0) ? k : 7 - k;
        if (!(x == 7 && y == 7)) begin
          if (x == 0 && y == 7) chk("win_not_early", won, 1'b0);
          pulse(C_STEP);
          finish_redraw("winstep");
        end
        if (k < 7) move((y % 2 == 0) ? C_RIGHT : C_LEFT);
      end
      if (y < 7) move(C_DOWN);
    end
    chk("win_map", stepMap, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("win_won", won, 1'b1);
    chk("win_lost", lost, 1'b0);
    chk("win_last_count", adj_count, 4'd0);

    // Reset asserted mid-COUNT clears everything, with no pending redraw
    mine_in = 64'h0000_0000_0000_0002;
    pulse(C_LOAD);
    chk("load4_won_clr", won, 1'b0);
    finish_redraw("load4");
    pulse(C_STEP);
    tick(); tick(); tick();
    chk("midcount_busy", busy, 1'b1);
    resetn = 1'b0;
    tick();
    chk("mrst_maps", mineMap | flagMap | stepMap, 64'h0);
    chk("mrst_cursor", {cursor_y, cursor_x}, 6'h0);
    chk("mrst_flags", {adj_count, adj_valid, redraw, busy, lost, won}, 9'h0);
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("mrst_no_redraw", redraw, 1'b0);
    chk("mrst_no_valid", adj_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
